exec_unit: RTL and testbench

Parametrised, handshaked execute unit for the RISC-V core: ALU, set-less-than, and branch-condition evaluation, with an iterative multi-cycle shifter. Sits between decode and writeback/PC-update. Generalises the fixed 32-bit single-cycle ALU operation/branch-condition set to arbitrary data width, a configurable shifter rate, SLT/SLTU, and the full RV32I branch-condition set, behind valid/ready handshakes on both sides.

---
 rtl/exec_unit.sv | 208 ++++++++++++++++++++
 tb/tb_exec_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Handshaked execute unit: ALU, set-less-than and branch-condition evaluation.
// Shifts run iteratively, up to SHIFT_STEP bits per cycle.
module exec_unit #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [2:0]       in_branch,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_taken,
  output logic             out_illegal
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW:0] STEP_AMT = SHIFT_STEP[CW:0];

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_JUMP = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;
  localparam logic [2:0] BR_EQ   = 3'd3;
  localparam logic [2:0] BR_LT   = 3'd4;
  localparam logic [2:0] BR_GE   = 3'd5;
  localparam logic [2:0] BR_LTU  = 3'd6;
  localparam logic [2:0] BR_GEU  = 3'd7;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [1:0]       sop_reg, sop_next;
  logic             taken_reg, taken_next;
  logic             illegal_reg, illegal_next;

  logic             accept;
  logic [CW-1:0]    shamt;
  logic             lt_s, lt_u, eq;
  logic             is_shift;
  logic             load_illegal;
  logic             branch_taken;
  logic [WIDTH-1:0] alu_result;
  logic [1:0]       load_sop;
  logic [CW:0]      step_amt;
  logic [CW-1:0]    cnt_after;
  logic [WIDTH-1:0] shifted;

  assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign shamt     = in_b[CW-1:0];
  assign lt_s      = $signed(in_a) < $signed(in_b);
  assign lt_u      = in_a < in_b;
  assign eq        = in_a == in_b;

  // Decode and single-cycle evaluation of the incoming request.
  always_comb begin
    alu_result   = '0;
    is_shift     = 1'b0;
    load_illegal = 1'b0;
    load_sop     = SH_SLL;
    case (in_op)
      OP_ADD:  alu_result = in_a + in_b;
      OP_SUB:  alu_result = in_a - in_b;
      OP_XOR:  alu_result = in_a ^ in_b;
      OP_OR:   alu_result = in_a | in_b;
      OP_AND:  alu_result = in_a & in_b;
      OP_SLL: begin
        alu_result = in_a;
        is_shift   = 1'b1;
        load_sop   = SH_SLL;
      end
      OP_SRL: begin
        alu_result = in_a;
        is_shift   = 1'b1;
        load_sop   = SH_SRL;
      end
      OP_SRA: begin
        alu_result = in_a;
        is_shift   = 1'b1;
        load_sop   = SH_SRA;
      end
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, lt_u};
      default: load_illegal = 1'b1;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (in_branch)
      BR_NONE: branch_taken = 1'b0;
      BR_JUMP: branch_taken = 1'b1;
      BR_NE:   branch_taken = !eq;
      BR_EQ:   branch_taken = eq;
      BR_LT:   branch_taken = lt_s;
      BR_GE:   branch_taken = !lt_s;
      BR_LTU:  branch_taken = lt_u;
      BR_GEU:  branch_taken = !lt_u;
      default: branch_taken = 1'b0;
    endcase
  end

  // One shifter iteration: min(SHIFT_STEP, remaining) bits.
  always_comb begin
    if ({1'b0, cnt_reg} < STEP_AMT) begin
      step_amt = {1'b0, cnt_reg};
    end else begin
      step_amt = STEP_AMT;
    end
    cnt_after = cnt_reg - step_amt[CW-1:0];
    case (sop_reg)
      SH_SRL:  shifted = result_reg >> step_amt;
      SH_SRA:  shifted = $signed(result_reg) >>> step_amt;
      default: shifted = result_reg << step_amt;
    endcase
  end

  // Next-state and next-output logic; an accept always overrides the retire path.
  always_comb begin
    state_next   = state_reg;
    result_next  = result_reg;
    cnt_next     = cnt_reg;
    sop_next     = sop_reg;
    taken_next   = taken_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      ST_SHIFT: begin
        result_next = shifted;
        cnt_next    = cnt_after;
        if (cnt_after == '0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (accept) begin
      illegal_next = load_illegal;
      taken_next   = branch_taken && !load_illegal;
      if (load_illegal) begin
        result_next = '0;
        state_next  = ST_DONE;
      end else if (is_shift && (shamt != '0)) begin
        result_next = in_a;
        cnt_next    = shamt;
        sop_next    = load_sop;
        state_next  = ST_SHIFT;
      end else begin
        result_next = alu_result;
        state_next  = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      result_reg  <= '0;
      cnt_reg     <= '0;
      sop_reg     <= SH_SLL;
      taken_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      result_reg  <= result_next;
      cnt_reg     <= cnt_next;
      sop_reg     <= sop_next;
      taken_reg   <= taken_next;
      illegal_reg <= illegal_next;
    end
  end

  assign out_valid   = (state_reg == ST_DONE);
  assign out_result  = result_reg;
  assign out_taken   = taken_reg;
  assign out_illegal = illegal_reg;

endmodule

// File: tb/tb_exec_unit.sv
// Randomized scoreboard bench for exec_unit (WIDTH 32, SHIFT_STEP 4) plus a
// directed latency check on a SHIFT_STEP 1 instance.
module tb_exec_unit;

  localparam int W    = 32;
  localparam int STEP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [2:0]    in_branch;
  logic [W-1:0]  in_a, in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_taken, out_illegal;

  logic          in_valid1, in_ready1;
  logic [3:0]    in_op1;
  logic [2:0]    in_branch1;
  logic [W-1:0]  in_a1, in_b1;
  logic          out_valid1, out_ready1;
  logic [W-1:0]  out_result1;
  logic          out_taken1, out_illegal1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    logic         taken;
    logic         ill;
    int           lat;
    int           acc_cyc;
    logic [3:0]   op;
    logic [2:0]   br;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  exec_unit #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_branch(in_branch), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_taken(out_taken), .out_illegal(out_illegal)
  );

  exec_unit #(.WIDTH(W), .SHIFT_STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_op(in_op1), .in_branch(in_branch1), .in_a(in_a1), .in_b(in_b1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_result(out_result1), .out_taken(out_taken1), .out_illegal(out_illegal1)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference behaviour from the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [2:0] br,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sh;
    sh = int'(b % W);
    e.op = op; e.br = br; e.a = a; e.b = b;
    e.ill = (op == 4'd0) || (op > 4'd10);
    case (op)
      4'd1:    e.res = a + b;
      4'd2:    e.res = a - b;
      4'd3:    e.res = a ^ b;
      4'd4:    e.res = a | b;
      4'd5:    e.res = a & b;
      4'd6:    e.res = a << sh;
      4'd7:    e.res = a >> sh;
      4'd8:    e.res = $signed(a) >>> sh;
      4'd9:    e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd10:   e.res = (a < b) ? 1 : 0;
      default: e.res = 0;
    endcase
    case (br)
      3'd1:    e.taken = 1'b1;
      3'd2:    e.taken = (a != b);
      3'd3:    e.taken = (a == b);
      3'd4:    e.taken = ($signed(a) < $signed(b));
      3'd5:    e.taken = ($signed(a) >= $signed(b));
      3'd6:    e.taken = (a < b);
      3'd7:    e.taken = (a >= b);
      default: e.taken = 1'b0;
    endcase
    if (e.ill) e.taken = 1'b0;
    if ((op >= 4'd6) && (op <= 4'd8) && (sh != 0)) e.lat = 1 + (sh + STEP - 1) / STEP;
    else e.lat = 1;
    e.acc_cyc = 0;
    return e;
  endfunction

  // Monitor: compares every cycle against the pending-request queue.
  initial begin
    exp_t e;
    bit   expv;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", {30'd0, out_taken, out_illegal}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        sb.delete();
      end else begin
        expv = (sb.size() > 0) && ((cyc - sb[0].acc_cyc) >= sb[0].lat);
        chk("out_valid", {31'd0, out_valid}, {31'd0, expv});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (sb.size() == 0) || (expv && out_ready)});
        if (expv && out_valid) begin
          chk("out_result", out_result, sb[0].res);
          chk("out_taken", {31'd0, out_taken}, {31'd0, sb[0].taken});
          chk("out_illegal", {31'd0, out_illegal}, {31'd0, sb[0].ill});
          if (out_ready) begin
            $display("txn op=%0d br=%0d a=%h b=%h result=%h taken=%b illegal=%b lat=%0d",
                     sb[0].op, sb[0].br, sb[0].a, sb[0].b, out_result, out_taken,
                     out_illegal, sb[0].lat);
            void'(sb.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          e = model(in_op, in_branch, in_a, in_b);
          e.acc_cyc = cyc;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] br,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bit done;
    in_valid = 1'b1; in_op = op; in_branch = br; in_a = a; in_b = b;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
      end else begin
        n++;
        if (n > 100) begin
          checks++;
          failures++;
          $display("FAIL accept_timeout actual=no_accept required=accept_within_100");
          done = 1'b1;
        end else begin
          tick();
        end
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  logic [2:0] br_list [8];
  logic [3:0] op_r;
  logic [W-1:0] a_r, b_r;
  int n1;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = 0; in_branch = 0; in_a = 0; in_b = 0;
    out_ready = 1'b1;
    in_valid1 = 1'b0; in_op1 = 0; in_branch1 = 0; in_a1 = 0; in_b1 = 0;
    out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // ALU boundary stream, back to back
    send(4'd1, 3'd0, 32'hFFFF_FFFF, 32'd1);
    send(4'd2, 3'd0, 32'd0, 32'd1);
    send(4'd9, 3'd0, 32'hFFFF_FFFF, 32'd1);
    send(4'd10, 3'd0, 32'hFFFF_FFFF, 32'd1);
    idle(2);

    // Branch conditions on A=-2, B=1
    br_list = '{3'd3, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd0};
    for (int i = 0; i < 8; i++) send(4'd1, br_list[i], 32'hFFFF_FFFE, 32'd1);
    idle(2);

    // Shifter timing and shamt masking
    send(4'd8, 3'd0, 32'h8000_0000, 32'd31);
    idle(12);
    send(4'd6, 3'd0, 32'h1234_5678, 32'd0);
    send(4'd6, 3'd0, 32'h0000_0003, 32'h25);
    send(4'd7, 3'd0, 32'hF000_0000, 32'hFFFF_FF24);
    idle(6);

    // Backpressure then simultaneous retire/accept
    send(4'd3, 3'd0, 32'h0000_00F0, 32'h0000_00FF);
    out_ready = 1'b0;
    idle(5);
    out_ready = 1'b1;
    send(4'd1, 3'd0, 32'd2, 32'd3);
    idle(2);

    // Illegal ops with a branch that would otherwise be taken
    send(4'd0, 3'd1, 32'd7, 32'd7);
    send(4'd13, 3'd1, 32'd7, 32'd7);
    idle(2);

    // Reset while shifting
    send(4'd6, 3'd0, 32'h0000_0001, 32'd20);
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("midshift_rst_valid", {31'd0, out_valid}, 0);
    chk("midshift_rst_result", out_result, 0);
    chk("midshift_rst_in_ready", {31'd0, in_ready}, 1);
    idle(2);
    rst_n = 1'b1;
    idle(10);

    // SHIFT_STEP 1 instance: full-length arithmetic shift
    in_valid1 = 1'b1; in_op1 = 4'd8; in_branch1 = 3'd0;
    in_a1 = 32'h8000_0000; in_b1 = 32'd31;
    @(negedge clk);
    chk("step1_in_ready", {31'd0, in_ready1}, 1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    n1 = 1;
    while (!out_valid1 && n1 < 100) begin
      @(posedge clk);
      #1;
      n1++;
    end
    chk("step1_latency", n1, 32);
    chk("step1_result", out_result1, 32'hFFFF_FFFF);
    idle(2);

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op_r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op_r = 4'($urandom_range(1, 10));
      a_r = $urandom();
      b_r = $urandom();
      case ($urandom_range(0, 5))
        0: b_r = a_r;
        1: a_r = 32'h8000_0000;
        2: b_r = 32'hFFFF_FFFF;
        default: ;
      endcase
      send(op_r, 3'($urandom_range(0, 7)), a_r, b_r);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    idle(20);
    chk("drain_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
